// File: rtl/mdp3_book_pkg.sv
// rtl/mdp3_book_pkg.sv - shared types and constants for the MDP3 depth book
package mdp3_book_pkg;

  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    NEW    = 2'd0,
    CHANGE = 2'd1,
    DELETE = 2'd2
  } action_e;

  typedef enum logic {
    BID   = 1'b0,
    OFFER = 1'b1
  } side_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_APPLY  = 2'd2
  } state_e;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/book_side_array.sv
// rtl/book_side_array.sv - one side of one book: DEPTH levels with New/Change/Delete update
module book_side_array
  import mdp3_book_pkg::*;
#(
  parameter int DEPTH   = 10,
  parameter int PRICE_W = 64,
  parameter int QTY_W   = 16,
  parameter int NORD_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  action_e            wr_op,
  input  logic [7:0]         wr_level,
  input  logic [PRICE_W-1:0] wr_price,
  input  logic [QTY_W-1:0]   wr_qty,
  input  logic [NORD_W-1:0]  wr_norders,
  input  logic [7:0]         rd_level,
  output logic               rd_present,
  output logic [PRICE_W-1:0] rd_price,
  output logic [QTY_W-1:0]   rd_qty,
  output logic [NORD_W-1:0]  rd_norders
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic               present;
    logic [PRICE_W-1:0] price;
    logic [QTY_W-1:0]   qty;
    logic [NORD_W-1:0]  norders;
  } level_entry_t;

  level_entry_t     entries_q [DEPTH];
  level_entry_t     entries_d [DEPTH];
  level_entry_t     wr_entry;
  level_entry_t     rd_entry;
  logic [7:0]       wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_entry = {1'b1, wr_price, wr_qty, wr_norders};
  assign wr_idx   = wr_level - 8'd1;

  // Entry g (level g+1) chooses between holding, the written entry, or a neighbour.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    level_entry_t up_ent;
    level_entry_t dn_ent;
    level_entry_t nxt;
    logic         at_lvl;
    logic         past_lvl;

    if (g == 0) begin : g_top
      assign up_ent = '0;
    end else begin : g_mid_up
      assign up_ent = entries_q[g-1];
    end

    if (g == DEPTH - 1) begin : g_bottom
      assign dn_ent = '0;
    end else begin : g_mid_dn
      assign dn_ent = entries_q[g+1];
    end

    assign at_lvl   = (wr_idx == 8'(g));
    assign past_lvl = (wr_idx < 8'(g));

    always_comb begin
      nxt = entries_q[g];
      if (wr_en) begin
        case (wr_op)
          NEW:     if (at_lvl) nxt = wr_entry; else if (past_lvl) nxt = up_ent;
          CHANGE:  if (at_lvl) nxt = wr_entry;
          DELETE:  if (at_lvl || past_lvl) nxt = dn_ent;
          default: nxt = entries_q[g];
        endcase
      end
    end

    assign entries_d[g] = nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entries_q <= '{default: '0};
    end else begin
      entries_q <= entries_d;
    end
  end

  assign rd_idx = rd_level[IDX_W-1:0] - IDX_W'(1);

  always_comb begin
    rd_entry = '0;
    if (rd_level != 8'd0 && rd_level <= 8'(DEPTH)) begin
      rd_entry = entries_q[rd_idx];
    end
  end

  assign rd_present = rd_entry.present;
  assign rd_price   = rd_entry.price;
  assign rd_qty     = rd_entry.qty;
  assign rd_norders = rd_entry.norders;

endmodule

// File: rtl/mdp3_depth_book.sv
// rtl/mdp3_depth_book.sv - multi-instrument MDP3 price book with read port and drop counter
module mdp3_depth_book
  import mdp3_book_pkg::*;
#(
  parameter int DEPTH     = 10,
  parameter int NUM_BOOKS = 2,
  parameter int PRICE_W   = 64,
  parameter int QTY_W     = 16,
  parameter int NORD_W    = 8,
  localparam int BOOK_W   = (NUM_BOOKS > 1) ? $clog2(NUM_BOOKS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    msg_valid,
  output logic                    msg_ready,
  input  logic [31:0]             msg_security_id,
  input  logic [1:0]              msg_action,
  input  logic [1:0]              msg_entry_type,
  input  logic [7:0]              msg_level,
  input  logic [PRICE_W-1:0]      msg_price,
  input  logic [QTY_W-1:0]        msg_qty,
  input  logic [NORD_W-1:0]       msg_norders,
  input  logic [32*NUM_BOOKS-1:0] sec_ids,
  output logic                    upd_valid,
  output logic [BOOK_W-1:0]       upd_book,
  output logic                    upd_side,
  input  logic                    rd_en,
  input  logic [BOOK_W-1:0]       rd_book,
  input  logic                    rd_side,
  input  logic [7:0]              rd_level,
  output logic                    rd_valid,
  output logic                    rd_present,
  output logic [PRICE_W-1:0]      rd_price,
  output logic [QTY_W-1:0]        rd_qty,
  output logic [NORD_W-1:0]       rd_norders,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  localparam int NUM_ARR = 2 * NUM_BOOKS;

  state_e                  state_q, state_d;
  logic                    msg_ready_q, msg_ready_d;
  logic [31:0]             sid_q, sid_d;
  logic [1:0]              act_q, act_d;
  logic [1:0]              etype_q, etype_d;
  logic [7:0]              level_q, level_d;
  logic [PRICE_W-1:0]      price_q, price_d;
  logic [QTY_W-1:0]        qty_q, qty_d;
  logic [NORD_W-1:0]       nord_q, nord_d;
  logic [BOOK_W-1:0]       book_q, book_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic                    upd_valid_q, upd_valid_d;
  logic [BOOK_W-1:0]       upd_book_q, upd_book_d;
  logic                    upd_side_q, upd_side_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_present_q, rd_present_d;
  logic [PRICE_W-1:0]      rd_price_q, rd_price_d;
  logic [QTY_W-1:0]        rd_qty_q, rd_qty_d;
  logic [NORD_W-1:0]       rd_nord_q, rd_nord_d;

  logic                    hit;
  logic [BOOK_W-1:0]       hit_book;
  logic                    lookup_drop;
  logic [BOOK_W:0]         rd_k;

  logic                    arr_present [NUM_ARR];
  logic [PRICE_W-1:0]      arr_price   [NUM_ARR];
  logic [QTY_W-1:0]        arr_qty     [NUM_ARR];
  logic [NORD_W-1:0]       arr_nord    [NUM_ARR];

  // Scan downward so the lowest matching book index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_book = '0;
    for (int b = NUM_BOOKS - 1; b >= 0; b--) begin
      if (sec_ids[32*b +: 32] == sid_q) begin
        hit      = 1'b1;
        hit_book = BOOK_W'(b);
      end
    end
  end

  assign lookup_drop = !hit || (act_q == 2'd3) || (etype_q > 2'd1) ||
                       (level_q == 8'd0) || (level_q > 8'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      msg_ready_q  <= 1'b0;
      sid_q        <= '0;
      act_q        <= '0;
      etype_q      <= '0;
      level_q      <= '0;
      price_q      <= '0;
      qty_q        <= '0;
      nord_q       <= '0;
      book_q       <= '0;
      drop_cnt_q   <= '0;
      upd_valid_q  <= 1'b0;
      upd_book_q   <= '0;
      upd_side_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_present_q <= 1'b0;
      rd_price_q   <= '0;
      rd_qty_q     <= '0;
      rd_nord_q    <= '0;
    end else begin
      state_q      <= state_d;
      msg_ready_q  <= msg_ready_d;
      sid_q        <= sid_d;
      act_q        <= act_d;
      etype_q      <= etype_d;
      level_q      <= level_d;
      price_q      <= price_d;
      qty_q        <= qty_d;
      nord_q       <= nord_d;
      book_q       <= book_d;
      drop_cnt_q   <= drop_cnt_d;
      upd_valid_q  <= upd_valid_d;
      upd_book_q   <= upd_book_d;
      upd_side_q   <= upd_side_d;
      rd_valid_q   <= rd_valid_d;
      rd_present_q <= rd_present_d;
      rd_price_q   <= rd_price_d;
      rd_qty_q     <= rd_qty_d;
      rd_nord_q    <= rd_nord_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sid_d      = sid_q;
    act_d      = act_q;
    etype_d    = etype_q;
    level_d    = level_q;
    price_d    = price_q;
    qty_d      = qty_q;
    nord_d     = nord_q;
    book_d     = book_q;
    drop_cnt_d = drop_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (msg_valid && msg_ready_q) begin
          state_d = ST_LOOKUP;
          sid_d   = msg_security_id;
          act_d   = msg_action;
          etype_d = msg_entry_type;
          level_d = msg_level;
          price_d = msg_price;
          qty_d   = msg_qty;
          nord_d  = msg_norders;
        end
      end
      ST_LOOKUP: begin
        if (lookup_drop) begin
          state_d    = ST_IDLE;
          drop_cnt_d = sat_inc(drop_cnt_q);
        end else begin
          state_d = ST_APPLY;
          book_d  = hit_book;
        end
      end
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    msg_ready_d = (state_d == ST_IDLE);
    upd_valid_d = (state_q == ST_APPLY);
    upd_book_d  = upd_book_q;
    upd_side_d  = upd_side_q;
    if (state_q == ST_APPLY) begin
      upd_book_d = book_q;
      upd_side_d = etype_q[0];
    end
  end

  for (genvar b = 0; b < NUM_BOOKS; b++) begin : g_book
    for (genvar s = 0; s < 2; s++) begin : g_side
      logic wr_en;
      assign wr_en = (state_q == ST_APPLY) && (book_q == BOOK_W'(b)) && (etype_q[0] == 1'(s));

      book_side_array #(
        .DEPTH   (DEPTH),
        .PRICE_W (PRICE_W),
        .QTY_W   (QTY_W),
        .NORD_W  (NORD_W)
      ) u_side (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_op      (action_e'(act_q)),
        .wr_level   (level_q),
        .wr_price   (price_q),
        .wr_qty     (qty_q),
        .wr_norders (nord_q),
        .rd_level   (rd_level),
        .rd_present (arr_present[2*b+s]),
        .rd_price   (arr_price[2*b+s]),
        .rd_qty     (arr_qty[2*b+s]),
        .rd_norders (arr_nord[2*b+s])
      );
    end
  end

  // Reads sample the arrays' current outputs, so a read on the APPLY edge sees old data.
  assign rd_k = {rd_book, rd_side};

  always_comb begin
    rd_valid_d   = rd_en;
    rd_present_d = rd_present_q;
    rd_price_d   = rd_price_q;
    rd_qty_d     = rd_qty_q;
    rd_nord_d    = rd_nord_q;
    if (rd_en) begin
      rd_present_d = 1'b0;
      rd_price_d   = '0;
      rd_qty_d     = '0;
      rd_nord_d    = '0;
      if (int'(rd_book) < NUM_BOOKS) begin
        rd_present_d = arr_present[rd_k];
        rd_price_d   = arr_price[rd_k];
        rd_qty_d     = arr_qty[rd_k];
        rd_nord_d    = arr_nord[rd_k];
      end
    end
  end

  assign msg_ready  = msg_ready_q;
  assign upd_valid  = upd_valid_q;
  assign upd_book   = upd_book_q;
  assign upd_side   = upd_side_q;
  assign rd_valid   = rd_valid_q;
  assign rd_present = rd_present_q;
  assign rd_price   = rd_price_q;
  assign rd_qty     = rd_qty_q;
  assign rd_norders = rd_nord_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
